cpu_req_sequencer: RTL and testbench

- Upstream stage for the sdram_ctrl CPU port; replaces the bench's fake-CPU glue with a real requester.
- Accepts 16/32-bit read, fetch and write requests on a valid/ready interface.
- Splits longwords into two big-endian word accesses, drives cpuAddr/cpustate/cpuL/cpuU/cpuWR, waits for cpuena, and returns assembled read data or a timeout error.

---
 rtl/cpu_req_sequencer_if.sv | 56 +++++
 rtl/cpu_req_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_req_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_req_sequencer_if.sv
`default_nettype none
// ============================================================================
// cpu_req_if / cpu_bus_if: request/response and sdram_ctrl CPU-port bundles
// Rev 1.0 - initial release
// ============================================================================

interface cpu_req_if #(
  parameter int AW = 26
);
  logic          req_valid;
  logic          req_ready;
  logic [AW:1]   req_addr;
  logic          req_long;
  logic          req_we;
  logic          req_fetch;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;

  modport master (
    output req_valid, req_addr, req_long, req_we, req_fetch, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_long, req_we, req_fetch, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface cpu_bus_if #(
  parameter int AW = 26
);
  logic [AW:1]   cpuAddr;
  logic [3:0]    cpustate;
  logic          cpuL;
  logic          cpuU;
  logic [15:0]   cpuWR;
  logic [15:0]   cpuRD;
  logic          enaWRreg;
  logic          cpuena;

  modport master (
    output cpuAddr, cpustate, cpuL, cpuU, cpuWR,
    input  cpuRD, enaWRreg, cpuena
  );

  modport slave (
    input  cpuAddr, cpustate, cpuL, cpuU, cpuWR,
    output cpuRD, enaWRreg, cpuena
  );
endinterface

`default_nettype wire

// File: rtl/cpu_req_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_req_sequencer: splits 16/32-bit CPU requests into sdram_ctrl word accesses
// Rev 1.0 - initial release
// ============================================================================

module cpu_req_sequencer #(
  parameter int addr_prefix_bits = 1,
  parameter int addr_max_bits    = 26,
  parameter int TIMEOUT          = 1024
) (
  input  logic      clk_114,
  input  logic      reset_n,
  cpu_req_if.slave  req,
  cpu_bus_if.master bus
);

  localparam int              AW       = addr_max_bits + addr_prefix_bits - 1;
  localparam int              TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:1]     ADDR_INC = AW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    GAP  = 3'd2,
    W1   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           init_q, init_d;
  logic [AW:1]    addr_q, addr_d;
  logic           long_q, long_d;
  logic           we_q, we_d;
  logic           fetch_q, fetch_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic           in_word;
  logic           hi_word;
  logic [1:0]     be_word;
  logic [1:0]     op;
  logic           word_done;

  always_ff @(posedge clk_114 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      addr_q  <= '0;
      long_q  <= 1'b0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      addr_q  <= addr_d;
      long_q  <= long_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // The high half of a longword always travels first (big-endian).
  always_comb begin
    in_word   = (state_q == W0) || (state_q == W1);
    hi_word   = (state_q == W0) && long_q;
    be_word   = hi_word ? be_q[3:2] : be_q[1:0];
    op        = we_q ? 2'b11 : (fetch_q ? 2'b00 : 2'b10);
    word_done = in_word && bus.enaWRreg && bus.cpuena;
  end

  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    addr_d  = addr_q;
    long_d  = long_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid && init_q) begin
          addr_d  = req.req_addr;
          long_d  = req.req_long;
          we_d    = req.req_we;
          fetch_d = req.req_fetch;
          be_d    = req.req_be;
          wdata_d = req.req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          if (req.req_we && (req.req_long ? (req.req_be == 4'b0000)
                                          : (req.req_be[1:0] == 2'b00))) begin
            state_d = RESP;
          end else if (req.req_we && req.req_long && (req.req_be[3:2] == 2'b00)) begin
            state_d = W1;
          end else begin
            state_d = W0;
          end
        end
      end
      W0, W1: begin
        tmo_d = tmo_q + TW'(1);
        // A late acknowledge in the final timeout cycle still counts as success.
        if (word_done) begin
          tmo_d = '0;
          if (!we_q) begin
            if (hi_word) rdata_d[31:16] = bus.cpuRD;
            else         rdata_d[15:0]  = bus.cpuRD;
          end
          if (hi_word && (!we_q || (be_q[1:0] != 2'b00))) state_d = GAP;
          else                                            state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
          tmo_d   = '0;
        end
      end
      GAP: begin
        tmo_d   = '0;
        state_d = W1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req.req_ready = init_q && (state_q == IDLE);
  assign req.rsp_valid = (state_q == RESP);
  assign req.rsp_err   = (state_q == RESP) && err_q;
  assign req.rsp_rdata = rdata_q;

  // Reads drive both strobes regardless of the requested enables.
  assign bus.cpuAddr  = (state_q == W1) ? addr_q + ADDR_INC : addr_q;
  assign bus.cpustate = in_word ? {long_q, 1'b0, op} : 4'b0101;
  assign bus.cpuU     = in_word ? (we_q ? ~be_word[1] : 1'b0) : 1'b1;
  assign bus.cpuL     = in_word ? (we_q ? ~be_word[0] : 1'b0) : 1'b1;
  assign bus.cpuWR    = hi_word ? wdata_q[31:16] : wdata_q[15:0];

endmodule

`default_nettype wire

// File: tb/tb_cpu_req_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_req_sequencer: random requests against an SDRAM responder and a memory model
// Rev 1.0 - initial release
// ============================================================================

module tb_cpu_req_sequencer;

  localparam int AW  = 26;
  localparam int TMO = 16;

  typedef struct {
    logic [AW:1] a;
    logic [3:0]  st;
    logic        l;
    logic        u;
    logic [15:0] wr;
    int          gap;
  } acc_t;

  logic clk;
  logic reset_n;

  cpu_req_if #(.AW(AW)) rq ();
  cpu_bus_if #(.AW(AW)) bus ();

  cpu_req_sequencer #(
    .addr_prefix_bits (1),
    .addr_max_bits    (26),
    .TIMEOUT          (TMO)
  ) dut (
    .clk_114 (clk),
    .reset_n (reset_n),
    .req     (rq),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_at   = -1;
  acc_t        obs_q[$];
  logic [15:0] sdram  [int];
  logic [15:0] shadow [int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(int k);
    return 16'((k * 40503) ^ 23130);
  endfunction

  function automatic logic [15:0] sdram_rd(int k);
    return sdram.exists(k) ? sdram[k] : init_val(k);
  endfunction

  function automatic logic [15:0] shadow_rd(int k);
    return shadow.exists(k) ? shadow[k] : init_val(k);
  endfunction

  function automatic void shadow_wr(int k, logic [1:0] be2, logic [15:0] w);
    logic [15:0] v;
    v = shadow_rd(k);
    if (be2[1]) v[15:8] = w[15:8];
    if (be2[0]) v[7:0]  = w[7:0];
    shadow[k] = v;
  endfunction

  task automatic preload(input logic [AW:1] a, input logic [15:0] v);
    sdram[int'(a)]  = v;
    shadow[int'(a)] = v;
  endtask

  // SDRAM stand-in: acknowledges word accesses after a bounded random wait.
  initial begin : responder
    int          idle_run;
    int          run_gap;
    int          run_cyc;
    int          k;
    bit          in_run;
    bit          en;
    bit          ack;
    acc_t        r;
    logic [15:0] v;
    idle_run = 0; run_gap = 0; run_cyc = 0; in_run = 0;
    bus.cpuRD = '0; bus.enaWRreg = 1'b0; bus.cpuena = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.cpustate[2]) begin
        if (!in_run) begin
          in_run  = 1;
          run_gap = idle_run;
          run_cyc = 0;
        end
        idle_run = 0;
        if (ack_at >= 0) begin
          en  = (run_cyc == ack_at) ? 1'b1 : 1'($urandom_range(0, 1));
          ack = (run_cyc == ack_at) ? 1'b1 : (en ? 1'b0 : 1'($urandom_range(0, 1)));
        end else begin
          en  = ($urandom_range(0, 3) != 0);
          ack = 1'($urandom_range(0, 1));
          if (run_cyc >= 6) begin
            en  = 1'b1;
            ack = 1'b1;
          end
        end
        bus.enaWRreg = en;
        bus.cpuena   = ack;
        k = int'(bus.cpuAddr);
        if (en && ack) begin
          bus.cpuRD = sdram_rd(k);
          r.a = bus.cpuAddr; r.st = bus.cpustate; r.l = bus.cpuL; r.u = bus.cpuU;
          r.wr = bus.cpuWR; r.gap = run_gap;
          obs_q.push_back(r);
          if (bus.cpustate[1:0] == 2'b11) begin
            v = sdram_rd(k);
            if (!bus.cpuU) v[15:8] = bus.cpuWR[15:8];
            if (!bus.cpuL) v[7:0]  = bus.cpuWR[7:0];
            sdram[k] = v;
          end
          in_run = 0;
        end else begin
          bus.cpuRD = 16'($urandom);
        end
        run_cyc++;
      end else begin
        in_run       = 0;
        idle_run++;
        bus.enaWRreg = 1'($urandom_range(0, 1));
        bus.cpuena   = 1'($urandom_range(0, 1));
        bus.cpuRD    = 16'($urandom);
      end
    end
  end

  task automatic check_reset_outputs();
    check_val("rst_req_ready", rq.req_ready, 0);
    check_val("rst_rsp_valid", rq.rsp_valid, 0);
    check_val("rst_rsp_err",   rq.rsp_err,   0);
    check_val("rst_rsp_rdata", rq.rsp_rdata, 0);
    check_val("rst_cpuAddr",   bus.cpuAddr,  0);
    check_val("rst_cpustate",  bus.cpustate, 4'b0101);
    check_val("rst_cpuL",      bus.cpuL,     1);
    check_val("rst_cpuU",      bus.cpuU,     1);
    check_val("rst_cpuWR",     bus.cpuWR,    0);
  endtask

  task automatic send_req(input logic [AW:1] a, input bit lng, input bit we, input bit fch,
                          input logic [3:0] be, input logic [31:0] wd);
    int g;
    g = 0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_addr = a; rq.req_long = lng; rq.req_we = we;
    rq.req_fetch = fch; rq.req_be = be; rq.req_wdata = wd;
    while (!rq.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_val("req_ready_wait", rq.req_ready, 1);
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    rq.req_addr  = AW'($urandom);
    rq.req_long  = 1'($urandom);
    rq.req_we    = 1'($urandom);
    rq.req_fetch = 1'($urandom);
    rq.req_be    = 4'($urandom);
    rq.req_wdata = $urandom;
  endtask

  task automatic do_req(input logic [AW:1] a, input bit lng, input bit we, input bit fch,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int exp_lat, input bit exp_err);
    acc_t        exp[$];
    acc_t        e;
    logic [AW:1] a1;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    int          lat;
    a1 = a + AW'(1);
    st = {lng, 1'b0, (we ? 2'b11 : (fch ? 2'b00 : 2'b10))};
    if (!exp_err) begin
      if (!we) begin
        e = '{a: a, st: st, l: 1'b0, u: 1'b0, wr: 16'h0, gap: -1};
        exp.push_back(e);
        if (lng) begin
          e.a = a1; e.gap = 1;
          exp.push_back(e);
        end
      end else if (lng) begin
        if (be[3:2] != 2'b00) begin
          e = '{a: a, st: st, l: ~be[2], u: ~be[3], wr: wd[31:16], gap: -1};
          exp.push_back(e);
        end
        if (be[1:0] != 2'b00) begin
          e = '{a: a1, st: st, l: ~be[0], u: ~be[1], wr: wd[15:0],
                gap: (be[3:2] != 2'b00) ? 1 : -1};
          exp.push_back(e);
        end
      end else if (be[1:0] != 2'b00) begin
        e = '{a: a, st: st, l: ~be[0], u: ~be[1], wr: wd[15:0], gap: -1};
        exp.push_back(e);
      end
    end
    if (exp_err)  exp_rd = 32'h0;
    else if (lng) exp_rd = {shadow_rd(int'(a)), shadow_rd(int'(a1))};
    else          exp_rd = {16'h0, shadow_rd(int'(a))};

    obs_q.delete();
    send_req(a, lng, we, fch, be, wd);
    lat = 0;
    while (!rq.rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("rsp_valid", rq.rsp_valid, 1);
    if (!rq.rsp_valid) return;
    if (exp_lat >= 0) check_val("latency", lat, exp_lat);
    check_val("rsp_err", rq.rsp_err, exp_err);
    if (!we || exp_err) check_val("rsp_rdata", rq.rsp_rdata, exp_rd);
    check_val("n_access", obs_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      check_val("acc_addr",    obs_q[i].a,  exp[i].a);
      check_val("acc_state",   obs_q[i].st, exp[i].st);
      check_val("acc_strobes", {obs_q[i].u, obs_q[i].l}, {exp[i].u, exp[i].l});
      if (we)            check_val("acc_wdata", obs_q[i].wr,  exp[i].wr);
      if (exp[i].gap >= 0) check_val("acc_gap", obs_q[i].gap, exp[i].gap);
    end
    if (we && !exp_err) begin
      if (lng) begin
        shadow_wr(int'(a),  be[3:2], wd[31:16]);
        shadow_wr(int'(a1), be[1:0], wd[15:0]);
      end else begin
        shadow_wr(int'(a), be[1:0], wd[15:0]);
      end
    end
    @(posedge clk);
    #1;
    check_val("rsp_pulse", rq.rsp_valid, 0);
    check_val("ready_after_rsp", rq.req_ready, 1);
  endtask

  initial begin : main
    logic [AW:1] top;
    logic [AW:1] a;
    logic [3:0]  be;
    bit          lng;
    bit          we;
    int          g;
    top = '1;
    rq.req_valid = 1'b0; rq.req_addr = '0; rq.req_long = 1'b0; rq.req_we = 1'b0;
    rq.req_fetch = 1'b0; rq.req_be = '0; rq.req_wdata = '0;
    reset_n = 1'b0;
    #3;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("ready_before_first_edge", rq.req_ready, 0);
    @(posedge clk);
    #1;
    check_val("ready_after_reset", rq.req_ready, 1);

    preload(26'h100, 16'h1234);
    preload(26'h101, 16'h5678);
    do_req(26'h100, 1, 0, 0, 4'hF, 32'h0, -1, 0);
    do_req(26'h200, 0, 1, 0, 4'b0010, 32'h0000ABCD, -1, 0);
    do_req(26'h200, 0, 0, 0, 4'b0011, 32'h0, -1, 0);
    do_req(26'h300, 1, 1, 0, 4'b0011, 32'hDEADBEEF, -1, 0);
    do_req(26'h302, 1, 1, 0, 4'b1100, 32'h89ABCDEF, -1, 0);
    do_req(26'h300, 1, 1, 0, 4'b0000, 32'h11112222, 0, 0);
    do_req(26'h304, 0, 1, 0, 4'b1100, 32'h33334444, 0, 0);
    do_req(26'h300, 1, 0, 0, 4'hF, 32'h0, -1, 0);
    do_req(26'h302, 1, 0, 1, 4'hF, 32'h0, -1, 0);

    preload(top, 16'hCAFE);
    preload('0, 16'hF00D);
    do_req(top, 1, 0, 0, 4'hF, 32'h0, -1, 0);
    do_req(top, 1, 1, 0, 4'b1001, 32'h5AA5C33C, -1, 0);
    do_req(top, 1, 0, 0, 4'h0, 32'h0, -1, 0);

    ack_at = 1000;
    do_req(26'h100, 0, 0, 0, 4'h3, 32'h0, TMO, 1);
    ack_at = TMO - 1;
    do_req(26'h101, 0, 0, 1, 4'h3, 32'h0, TMO, 0);
    ack_at = -1;
    do_req(26'h100, 1, 0, 0, 4'hF, 32'h0, -1, 0);

    obs_q.delete();
    send_req(26'h100, 1, 0, 0, 4'hF, 32'h0);
    g = 0;
    while (obs_q.size() == 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    ack_at = 1000;
    repeat (3) @(negedge clk);
    check_val("w1_state", bus.cpustate, 4'b1010);
    check_val("w1_addr",  bus.cpuAddr,  26'h101);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("no_rsp_in_reset", rq.rsp_valid, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_at  = -1;
    #1;
    check_val("ready_low_at_release", rq.req_ready, 0);
    @(posedge clk);
    #1;
    check_val("ready_after_release", rq.req_ready, 1);
    check_val("no_rsp_after_release", rq.rsp_valid, 0);
    do_req(26'h104, 0, 0, 1, 4'h3, 32'h0, -1, 0);
    do_req(26'h105, 1, 0, 1, 4'hF, 32'h0, -1, 0);

    for (int i = 0; i < 60; i++) begin
      a   = ($urandom_range(0, 7) == 0) ? top : AW'(26'h100 + $urandom_range(0, 7));
      lng = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom);
      do_req(a, lng, we, 1'($urandom_range(0, 1)), be, $urandom,
             (we && (lng ? (be == 4'h0) : (be[1:0] == 2'b00))) ? 0 : -1, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
